cache_maint_ctrl: RTL and testbench

- Sequences maintenance operations (clean, invalidate, clean+invalidate) on the direct-mapped writeback cache memory, either for a single address or by walking every line.
- Arbitrates cache ownership with the cache's normal AHB control FSM using a req/gnt handshake.
- Writes dirty lines back downstream through its own AHB-Lite master port.
- Sits beside the writeback cache; its cache-side outputs are muxed into the cache memory while the grant is held.

---
 rtl/cache_maint_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_maint_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_maint_ctrl.sv
// Maintenance sequencer (clean / invalidate / clean+invalidate) for the direct-mapped writeback cache.
// Optional writeback counter output wb_count is enabled by defining CACHE_MAINT_WB_COUNT_EN.
module cache_maint_ctrl #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic              req_all,
   input  logic [W_ADDR-1:0] req_addr,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              maint_req,
   input  logic              maint_gnt,
   output logic [W_ADDR-1:0] cache_addr,
   output logic              cache_ren,
   output logic              cache_clean,
   output logic              cache_invalidate,
   input  logic [W_DATA-1:0] cache_rdata,
   input  logic              cache_hit,
   input  logic              cache_dirty,
   input  logic [W_ADDR-1:0] cache_dirty_addr,
   input  logic              dst_hready,
   input  logic              dst_hresp,
   output logic [W_ADDR-1:0] dst_haddr,
   output logic              dst_hwrite,
   output logic [1:0]        dst_htrans,
   output logic [2:0]        dst_hsize,
   output logic [2:0]        dst_hburst,
   output logic [3:0]        dst_hprot,
   output logic              dst_hmastlock,
   output logic [W_DATA-1:0] dst_hwdata
`ifdef CACHE_MAINT_WB_COUNT_EN
   ,
   output logic [15:0]       wb_count
`endif
);

   localparam int LB = $clog2(W_DATA / 8);
   localparam int IW = $clog2(DEPTH);
   localparam logic [W_ADDR-1:0] ADDR_LOW_MASK = (W_ADDR'(1) << LB) - W_ADDR'(1);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      LOOKUP,
      CHECK,
      WB_APH,
      WB_DPH,
      UPDATE,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic              all_q, all_d;
   logic [W_ADDR-1:0] addr_q, addr_d;
   logic              errAcc_q, errAcc_d;
   logic [IW-1:0]     index_q, index_d;
   logic [W_DATA-1:0] rdata_q, rdata_d;
   logic [W_ADDR-1:0] dirtyAddr_q, dirtyAddr_d;
   logic              failed_q, failed_d;
   logic [W_ADDR-1:0] lookupAddr;

`ifdef CACHE_MAINT_WB_COUNT_EN
   logic [15:0]       wbCount_q, wbCount_d;
   assign wb_count = wbCount_q;
`endif

   assign dst_hburst    = 3'b000;
   assign dst_hprot     = 4'b0011;
   assign dst_hmastlock = 1'b0;

   // Walks step one word-sized line per index; single ops use the latched address.
   assign lookupAddr = all_q ? (W_ADDR'(index_q) << LB) : addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         all_q       <= 1'b0;
         addr_q      <= '0;
         errAcc_q    <= 1'b0;
         index_q     <= '0;
         rdata_q     <= '0;
         dirtyAddr_q <= '0;
         failed_q    <= 1'b0;
`ifdef CACHE_MAINT_WB_COUNT_EN
         wbCount_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         all_q       <= all_d;
         addr_q      <= addr_d;
         errAcc_q    <= errAcc_d;
         index_q     <= index_d;
         rdata_q     <= rdata_d;
         dirtyAddr_q <= dirtyAddr_d;
         failed_q    <= failed_d;
`ifdef CACHE_MAINT_WB_COUNT_EN
         wbCount_q   <= wbCount_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      all_d            = all_q;
      addr_d           = addr_q;
      errAcc_d         = errAcc_q;
      index_d          = index_q;
      rdata_d          = rdata_q;
      dirtyAddr_d      = dirtyAddr_q;
      failed_d         = failed_q;
`ifdef CACHE_MAINT_WB_COUNT_EN
      wbCount_d        = wbCount_q;
`endif
      req_ready        = 1'b0;
      done             = 1'b0;
      err              = 1'b0;
      busy             = 1'b1;
      maint_req        = 1'b0;
      cache_addr       = '0;
      cache_ren        = 1'b0;
      cache_clean      = 1'b0;
      cache_invalidate = 1'b0;
      dst_haddr        = '0;
      dst_hwrite       = 1'b0;
      dst_htrans       = HTRANS_IDLE;
      dst_hsize        = 3'b000;
      dst_hwdata       = '0;

      case (state_q)
         IDLE: begin
            busy      = 1'b0;
            req_ready = 1'b1;
            if (req_valid) begin
               op_d     = req_op;
               all_d    = req_all;
               addr_d   = req_addr;
               errAcc_d = 1'b0;
               index_d  = '0;
`ifdef CACHE_MAINT_WB_COUNT_EN
               wbCount_d = '0;
`endif
               state_d  = (req_op == 2'b00) ? DONE : GRANT;
            end
         end
         GRANT: begin
            maint_req = 1'b1;
            if (maint_gnt) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            maint_req  = 1'b1;
            cache_ren  = 1'b1;
            cache_addr = lookupAddr;
            failed_d   = 1'b0;
            state_d    = CHECK;
         end
         CHECK: begin
            maint_req   = 1'b1;
            rdata_d     = cache_rdata;
            dirtyAddr_d = cache_dirty_addr;
            if (!all_q && !cache_hit) begin
               state_d = DONE;
            end else if (op_q[0] && cache_dirty) begin
               state_d = WB_APH;
            end else begin
               state_d = UPDATE;
            end
         end
         WB_APH: begin
            maint_req  = 1'b1;
            dst_htrans = HTRANS_NONSEQ;
            dst_hwrite = 1'b1;
            dst_hsize  = 3'(LB);
            dst_haddr  = dirtyAddr_q & ~ADDR_LOW_MASK;
            if (dst_hready) begin
               state_d = WB_DPH;
            end
         end
         WB_DPH: begin
            maint_req  = 1'b1;
            dst_hwdata = rdata_q;
            if (dst_hready) begin
               if (dst_hresp) begin
                  errAcc_d = 1'b1;
                  failed_d = 1'b1;
               end
`ifdef CACHE_MAINT_WB_COUNT_EN
               else if (wbCount_q != 16'hffff) begin
                  wbCount_d = wbCount_q + 16'd1;
               end
`endif
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            maint_req        = 1'b1;
            cache_addr       = lookupAddr;
            cache_invalidate = op_q[1];
            // A line whose writeback failed must keep its dirty data.
            cache_clean      = op_q[0] && !op_q[1] && !failed_q;
            if (!all_q || (index_q == IW'(DEPTH - 1))) begin
               state_d = DONE;
            end else begin
               index_d = index_q + 1'b1;
               state_d = LOOKUP;
            end
         end
         DONE: begin
            done    = 1'b1;
            err     = errAcc_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_maint_ctrl.sv
// Scoreboard bench for cache_maint_ctrl with a small cache-response model and AHB-Lite slave.
module tb_cache_maint_ctrl;

   localparam int W_ADDR = 32;
   localparam int W_DATA = 32;
   localparam int DEPTH  = 4;
   localparam int K_CLEAN = 0;
   localparam int K_INV   = 1;
   localparam int K_WR    = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = 2'b00;
   logic              req_all = 1'b0;
   logic [W_ADDR-1:0] req_addr = '0;
   logic              done, err, busy, maint_req;
   logic              maint_gnt = 1'b1;
   logic [W_ADDR-1:0] cache_addr;
   logic              cache_ren, cache_clean, cache_invalidate;
   logic [W_DATA-1:0] cache_rdata;
   logic              cache_hit, cache_dirty;
   logic [W_ADDR-1:0] cache_dirty_addr;
   logic              dst_hready = 1'b1;
   logic              dst_hresp = 1'b0;
   logic [W_ADDR-1:0] dst_haddr;
   logic              dst_hwrite;
   logic [1:0]        dst_htrans;
   logic [2:0]        dst_hsize, dst_hburst;
   logic [3:0]        dst_hprot;
   logic              dst_hmastlock;
   logic [W_DATA-1:0] dst_hwdata;
`ifdef CACHE_MAINT_WB_COUNT_EN
   logic [15:0]       wb_count;
`endif

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Cache model: per-line dirty/data/address, responding the cycle after cache_ren.
   logic [3:0]  lineDirty = 4'b0000;
   logic [31:0] lineData [4];
   logic [31:0] lineDAddr [4];
   logic        hitAll = 1'b1;
   logic [1:0]  lkIdx = 2'b00;

   always @(posedge clk) begin
      if (cache_ren) lkIdx <= cache_addr[3:2];
   end

   assign cache_hit        = hitAll;
   assign cache_dirty      = lineDirty[lkIdx];
   assign cache_rdata      = lineData[lkIdx];
   assign cache_dirty_addr = lineDAddr[lkIdx];

   // Downstream slave: zero-wait OKAY, optional two-cycle ERROR, optional address-phase stall.
   logic errMode = 1'b0;
   logic stallApH = 1'b0;
   int   slvStage = 0;

   always @(posedge clk) begin
      if (slvStage == 0 && dst_htrans == 2'b10 && dst_hready && errMode) begin
         dst_hready <= 1'b0;
         dst_hresp  <= 1'b1;
         slvStage   <= 1;
      end else if (slvStage == 1) begin
         dst_hready <= 1'b1;
         dst_hresp  <= 1'b1;
         slvStage   <= 2;
      end else begin
         dst_hready <= !stallApH;
         dst_hresp  <= 1'b0;
         slvStage   <= 0;
      end
   end

   always #5 clk = ~clk;

   cache_maint_ctrl #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_all(req_all), .req_addr(req_addr),
      .done(done), .err(err), .busy(busy),
      .maint_req(maint_req), .maint_gnt(maint_gnt),
      .cache_addr(cache_addr), .cache_ren(cache_ren),
      .cache_clean(cache_clean), .cache_invalidate(cache_invalidate),
      .cache_rdata(cache_rdata), .cache_hit(cache_hit),
      .cache_dirty(cache_dirty), .cache_dirty_addr(cache_dirty_addr),
      .dst_hready(dst_hready), .dst_hresp(dst_hresp),
      .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
      .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
      .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata)
`ifdef CACHE_MAINT_WB_COUNT_EN
      , .wb_count(wb_count)
`endif
   );

   task automatic pushExp(input int kind, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
   endtask

   // Presents one command for a single cycle; returns just after the accepting edge.
   task automatic issueCmd(input logic [1:0] op, input logic all, input logic [31:0] addr);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_all   = all;
      req_addr  = addr;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Scoreboard drain: pops expectations as cache events and writebacks appear, until done.
   task automatic drainToDone(input int startCyc, output int doneCyc, output logic errOut,
                              output int busyBad);
      int          cyc;
      logic        pend;
      logic [31:0] pAddr;
      exp_t        e;
      int          kind;
      cyc     = startCyc;
      pend    = 1'b0;
      pAddr   = '0;
      doneCyc = -1;
      errOut  = 1'bx;
      busyBad = 0;
      while (cyc < startCyc + 200) begin
         @(negedge clk);
         cyc++;
         if (!busy || req_ready) busyBad++;
         if (cache_clean || cache_invalidate) begin
            vectors++;
            kind = cache_invalidate ? K_INV : K_CLEAN;
            if (cache_clean && cache_invalidate) begin
               miscompares++;
               $display("[TB] FAIL cache_evt: clean and invalidate both high at addr %h, required one", cache_addr);
            end else if (expQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL cache_evt: got kind %0d addr %h, required no event", kind, cache_addr);
            end else begin
               e = expQ.pop_front();
               if (e.kind !== kind || e.addr !== cache_addr) begin
                  miscompares++;
                  $display("[TB] FAIL cache_evt: got kind %0d addr %h, required kind %0d addr %h",
                           kind, cache_addr, e.kind, e.addr);
               end
            end
         end
         if (pend && dst_hready) begin
            vectors++;
            pend = 1'b0;
            if (expQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL writeback: got haddr %h hwdata %h, required no write", pAddr, dst_hwdata);
            end else begin
               e = expQ.pop_front();
               if (e.kind !== K_WR || e.addr !== pAddr || e.data !== dst_hwdata) begin
                  miscompares++;
                  $display("[TB] FAIL writeback: got haddr %h hwdata %h, required kind %0d haddr %h hwdata %h",
                           pAddr, dst_hwdata, e.kind, e.addr, e.data);
               end
            end
         end
         if (dst_htrans == 2'b10 && dst_hready) begin
            pend  = 1'b1;
            pAddr = dst_haddr;
            vectors++;
            if (dst_hwrite !== 1'b1 || dst_hsize !== 3'd2) begin
               miscompares++;
               $display("[TB] FAIL aph_ctrl: hwrite %b hsize %0d, required 1 and 2", dst_hwrite, dst_hsize);
            end
         end
         if (done) begin
            doneCyc = cyc;
            errOut  = err;
            break;
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic all, input logic [31:0] addr,
                                input int expDone, input logic expErr, input string name);
      int   doneCyc, busyBad;
      logic errOut;
      issueCmd(op, all, addr);
      drainToDone(0, doneCyc, errOut, busyBad);
      vectors++;
      if (doneCyc !== expDone) begin
         miscompares++;
         $display("[TB] FAIL %s done_cycle: got %0d, required %0d", name, doneCyc, expDone);
      end
      vectors++;
      if (errOut !== expErr) begin
         miscompares++;
         $display("[TB] FAIL %s err: got %b, required %b", name, errOut, expErr);
      end
      vectors++;
      if (expQ.size() != 0 || busyBad != 0) begin
         miscompares++;
         $display("[TB] FAIL %s leftovers: got %0d pending and %0d busy glitches, required 0 and 0",
                  name, expQ.size(), busyBad);
      end
      expQ.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({req_ready, busy, done, err, maint_req, cache_ren, cache_clean, cache_invalidate,
           dst_htrans, dst_hwrite} !== 11'b100_0000_0000) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %b, required %b",
                  {req_ready, busy, done, err, maint_req, cache_ren, cache_clean, cache_invalidate,
                   dst_htrans, dst_hwrite}, 11'b100_0000_0000);
      end
      vectors++;
      if ({dst_hburst, dst_hprot, dst_hmastlock} !== 8'b000_0011_0) begin
         miscompares++;
         $display("[TB] FAIL tie_offs: got %b, required %b", {dst_hburst, dst_hprot, dst_hmastlock}, 8'b000_0011_0);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_walk();
      lineDirty = 4'b0000;
      for (int i = 0; i < 4; i++) pushExp(K_CLEAN, 32'(i * 4), '0);
      applyStimulus(2'b01, 1'b1, 32'h0, 14, 1'b0, "clean_walk");
   endtask

   task automatic test_dirty_clean_inv();
      lineDirty    = 4'b0100;
      lineDAddr[2] = 32'h0000_1008;
      lineData[2]  = 32'hDEAD_BEEF;
      pushExp(K_INV, 32'h0, '0);
      pushExp(K_INV, 32'h4, '0);
      pushExp(K_WR, 32'h0000_1008, 32'hDEAD_BEEF);
      pushExp(K_INV, 32'h8, '0);
      pushExp(K_INV, 32'hC, '0);
      applyStimulus(2'b11, 1'b1, 32'h0, 16, 1'b0, "dirty_clean_inv");
`ifdef CACHE_MAINT_WB_COUNT_EN
      vectors++;
      if (wb_count !== 16'd1) begin
         miscompares++;
         $display("[TB] FAIL wb_count_ok: got %0d, required 1", wb_count);
      end
`endif
   endtask

   task automatic test_single_miss();
      hitAll = 1'b0;
      applyStimulus(2'b01, 1'b0, 32'h0000_2004, 4, 1'b0, "single_miss");
      hitAll = 1'b1;
   endtask

   task automatic test_single_hit();
      lineDirty    = 4'b0100;
      lineDAddr[2] = 32'h0000_3008;
      lineData[2]  = 32'hA5A5_0001;
      pushExp(K_WR, 32'h0000_3008, 32'hA5A5_0001);
      pushExp(K_CLEAN, 32'h0000_3008, '0);
      applyStimulus(2'b01, 1'b0, 32'h0000_3008, 7, 1'b0, "single_hit");
   endtask

   task automatic test_wb_error();
      lineDirty    = 4'b0010;
      lineDAddr[1] = 32'h0000_2006;
      lineData[1]  = 32'h1234_5678;
      errMode      = 1'b1;
      pushExp(K_CLEAN, 32'h0, '0);
      pushExp(K_WR, 32'h0000_2004, 32'h1234_5678);
      pushExp(K_CLEAN, 32'h8, '0);
      pushExp(K_CLEAN, 32'hC, '0);
      applyStimulus(2'b01, 1'b1, 32'h0, 17, 1'b1, "wb_error");
      errMode = 1'b0;
`ifdef CACHE_MAINT_WB_COUNT_EN
      vectors++;
      if (wb_count !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL wb_count_err: got %0d, required 0", wb_count);
      end
`endif
   endtask

   task automatic test_gnt_delay();
      int   doneCyc, busyBad;
      logic errOut;
      lineDirty = 4'b0000;
      maint_gnt = 1'b0;
      pushExp(K_INV, 32'h0000_0040, '0);
      issueCmd(2'b10, 1'b0, 32'h0000_0040);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) begin
            req_valid = 1'b1;
            req_op    = 2'b11;
            req_all   = 1'b1;
         end
         vectors++;
         if ({busy, req_ready, maint_req, cache_ren} !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL gnt_wait cycle %0d: busy/ready/mreq/ren %b, required 1010", i,
                     {busy, req_ready, maint_req, cache_ren});
         end
      end
      req_valid = 1'b0;
      maint_gnt = 1'b1;
      @(negedge clk);
      vectors++;
      if (cache_ren !== 1'b1 || cache_addr !== 32'h0000_0040) begin
         miscompares++;
         $display("[TB] FAIL gnt_lookup: ren %b addr %h, required 1 and 00000040", cache_ren, cache_addr);
      end
      drainToDone(11, doneCyc, errOut, busyBad);
      vectors++;
      if (doneCyc !== 14 || errOut !== 1'b0 || expQ.size() != 0 || busyBad != 0) begin
         miscompares++;
         $display("[TB] FAIL gnt_done: cycle %0d err %b pending %0d glitches %0d, required 14 0 0 0",
                  doneCyc, errOut, expQ.size(), busyBad);
      end
      expQ.delete();
   endtask

   task automatic test_reset_mid();
      bit found;
      lineDirty    = 4'b0001;
      lineDAddr[0] = 32'h0000_5000;
      stallApH     = 1'b1;
      found        = 1'b0;
      issueCmd(2'b01, 1'b1, 32'h0);
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (dst_htrans == 2'b10) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("[TB] FAIL reach_aph: got no NONSEQ within 50 cycles, required NONSEQ");
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({dst_htrans, maint_req, req_ready, busy} !== 5'b00010) begin
         miscompares++;
         $display("[TB] FAIL reset_mid: htrans/mreq/ready/busy %b, required 00010",
                  {dst_htrans, maint_req, req_ready, busy});
      end
      rst      = 1'b0;
      stallApH = 1'b0;
      expQ.delete();
      applyStimulus(2'b00, 1'b0, 32'h0, 1, 1'b0, "op_zero");
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         lineData[i]  = 32'h1000_0000 + 32'(i);
         lineDAddr[i] = 32'h0000_0100 + 32'(i * 4);
      end
      test_reset();
      test_clean_walk();
      test_dirty_clean_inv();
      test_single_miss();
      test_single_hit();
      test_wb_error();
      test_gnt_delay();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
